// File: rtl/lsu_pkg.sv
// lsu_pkg: shared states, access sizes, funct3/opcode encodings and size helper for the load/store unit
package lsu_pkg;
    typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, DONE} lsu_state_t;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        return 4'd1 << sz;
    endfunction
endpackage

// File: rtl/byte_lane_merge.sv
// byte_lane_merge: overlays the low size bytes of wdata onto old_dw starting at lane offset; lanes past 7 are dropped
module byte_lane_merge
    import lsu_pkg::*;
(
    input  logic [63:0] old_dw,
    input  logic [63:0] wdata,
    input  logic [2:0]  offset,
    input  logic [1:0]  size,
    output logic [63:0] merged,
    output logic [7:0]  mask
);
    logic [7:0]  w_base;
    logic [63:0] w_shifted;
    assign w_base    = 8'((9'd1 << size_bytes(size)) - 9'd1);
    assign mask      = w_base << offset;
    assign w_shifted = wdata << {offset, 3'b000};
    for (genvar g = 0; g < 8; g++) begin : g_lane
        assign merged[8*g +: 8] = mask[g] ? w_shifted[8*g +: 8] : old_dw[8*g +: 8];
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multicycle data-memory access stage with read-modify-write sub-doubleword stores; LSU_MISALIGN_TRAP_EN adds a misalign trap output
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] load_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic              misalign,
`endif
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);
    lsu_state_t  r_state;
    logic [2:0]  r_off;
    logic [1:0]  r_size;
    logic        r_store;
    logic [63:0] r_sdata;
    logic [63:0] r_rdbuf;
    logic [63:0] w_rd_shift;
    logic [63:0] w_ld;
    logic [63:0] w_merged;
    logic [7:0]  w_ld_mask;
    logic [7:0]  w_st_mask;
    logic        w_unused;
`ifdef LSU_MISALIGN_TRAP_EN
    logic [3:0]  w_nb;
    logic        w_misalign;
    assign w_nb       = size_bytes(funct3[1:0]);
    assign w_misalign = |(addr[2:0] & 3'(w_nb - 4'd1));
`endif
    // signedness (funct3[2]) is handled downstream; masks only feed the data path
    assign w_unused   = ^{funct3[2], w_ld_mask, w_st_mask};
    assign w_rd_shift = mem_rdata >> {r_off, 3'b000};

    // load path: right-align then keep size bytes, zero above
    byte_lane_merge u_load_mask (
        .old_dw (64'd0),
        .wdata  (w_rd_shift),
        .offset (3'd0),
        .size   (r_size),
        .merged (w_ld),
        .mask   (w_ld_mask)
    );

    // store path: insert store bytes into the doubleword read back from memory
    byte_lane_merge u_store_merge (
        .old_dw (r_rdbuf),
        .wdata  (r_sdata),
        .offset (r_off),
        .size   (r_size),
        .merged (w_merged),
        .mask   (w_st_mask)
    );

    // access sequencer with registered memory interface and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_off     <= '0;
            r_size    <= '0;
            r_store   <= 1'b0;
            r_sdata   <= '0;
            r_rdbuf   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            load_data <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_off    <= addr[2:0];
                        r_size   <= funct3[1:0];
                        r_store  <= is_store;
                        r_sdata  <= store_data;
                        mem_addr <= {addr[ADDR_W-1:3], 3'b000};
                        busy     <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (w_misalign) begin
                            done     <= 1'b1;
                            misalign <= 1'b1;
                            r_state  <= DONE;
                        end else
`endif
                        begin
                            mem_req <= 1'b1;
                            if (is_store && funct3[1:0] == SZ_D) begin
                                mem_we    <= 1'b1;
                                mem_wdata <= store_data;
                                r_state   <= WRITE;
                            end else begin
                                mem_we  <= 1'b0;
                                r_state <= READ;
                            end
                        end
                    end
                end
                READ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (r_store) begin
                            r_rdbuf <= mem_rdata;
                            r_state <= MERGE;
                        end else begin
                            load_data <= w_ld;
                            done      <= 1'b1;
                            r_state   <= DONE;
                        end
                    end
                end
                MERGE: begin
                    mem_req   <= 1'b1;
                    mem_we    <= 1'b1;
                    mem_wdata <= w_merged;
                    r_state   <= WRITE;
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                    misalign <= 1'b0;
`endif
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
